nubus_vram_arbiter: RTL

//  Shares the single SDRAM VRAM port between the video scan-out fetcher and the NuBus CPU slot logic.

---
 rtl/nubus_vram_pkg.sv | 9 +
 rtl/nubus_vram_arb_pick.sv | 19 +
 rtl/nubus_vram_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nubus_vram_pkg.sv
// nubus_vram_pkg: shared types and sizes for the NuBus VRAM arbiter
package nubus_vram_pkg;
  localparam int VADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int MADDR_W = 25;
  localparam int VRAM_WORDS_C = 153600;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {GNT_VID, GNT_CPU} grant_t;
endpackage

// File: rtl/nubus_vram_arb_pick.sv
// nubus_vram_arb_pick: picks video or CPU from pending requests, urgency and starvation count
module nubus_vram_arb_pick
  import nubus_vram_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             i_vid_req,
  input  logic             i_cpu_req,
  input  logic             i_vid_urgent,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output grant_t           o_grant,
  output logic             o_valid
);
  logic w_vid_wins;
  assign w_vid_wins = i_vid_req && (!i_cpu_req || (i_vid_urgent && i_starve_cnt < CNT_W'(STARVE_MAX)));
  assign o_grant = w_vid_wins ? GNT_VID : GNT_CPU;
  assign o_valid = i_vid_req || i_cpu_req;
endmodule

// File: rtl/nubus_vram_arbiter.sv
// nubus_vram_arbiter: shares the SDRAM VRAM port between video scan-out and NuBus CPU
// Optional access timeout with sticky error flag when VRAM_ARB_TIMEOUT_EN is defined.
module nubus_vram_arbiter
  import nubus_vram_pkg::*;
#(
  parameter logic [MADDR_W-1:0] VRAM_BASE = 25'h0,
  parameter int VRAM_WORDS = VRAM_WORDS_C,
  parameter int STARVE_MAX = 4
`ifdef VRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_vid_req,
  input  logic               i_vid_urgent,
  input  logic [VADDR_W-1:0] i_vid_addr,
  output logic               o_vid_ack,
  output logic [DATA_W-1:0]  o_vid_rdata,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [1:0]         i_cpu_be,
  input  logic [VADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0]  i_cpu_wdata,
  output logic               o_cpu_ack,
  output logic [DATA_W-1:0]  o_cpu_rdata,
  output logic [MADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_dout,
  output logic [1:0]         o_mem_be,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  input  logic [DATA_W-1:0]  i_mem_din,
  input  logic               i_mem_ready,
  output logic               o_busy,
  output logic               o_timeout_err
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  arb_state_t r_state;
  grant_t r_gnt, w_grant;
  logic r_we, w_valid, w_idle_gnt, w_we, w_in_range, w_tmo, w_cpu_gnt;
  logic [CNT_W-1:0] r_starve;
  logic [VADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rdata;
  logic r_vid_ack, r_cpu_ack, r_mem_rd, r_mem_wr;
  logic [DATA_W-1:0] r_vid_rdata, r_cpu_rdata, r_mem_dout;
  logic [MADDR_W-1:0] r_mem_addr;
  logic [1:0] r_mem_be;
  nubus_vram_arb_pick #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_pick (
    .i_vid_req   (i_vid_req),
    .i_cpu_req   (i_cpu_req),
    .i_vid_urgent(i_vid_urgent),
    .i_starve_cnt(r_starve),
    .o_grant     (w_grant),
    .o_valid     (w_valid)
  );
  assign w_idle_gnt = r_state == IDLE && w_valid;
  assign w_cpu_gnt = w_grant == GNT_CPU;
  assign w_addr = w_cpu_gnt ? i_cpu_addr : i_vid_addr;
  assign w_we = w_cpu_gnt && i_cpu_we;
  assign w_in_range = 32'(w_addr) < 32'(VRAM_WORDS);
  // a timed-out read returns zero instead of whatever is on the bus
  assign w_rdata = i_mem_ready ? i_mem_din : '0;
`ifdef VRAM_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic r_timeout_err;
  assign w_tmo = r_state == ACCESS && r_tmo_cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_tmo_cnt <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == ACCESS) ? r_tmo_cnt + 16'd1 : '0;
      r_timeout_err <= r_timeout_err || (w_tmo && !i_mem_ready);
    end
  assign o_timeout_err = r_timeout_err;
`else
  assign w_tmo = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_gnt <= GNT_VID;
      r_we <= 1'b0;
      r_starve <= '0;
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_vid_rdata <= '0;
      r_cpu_rdata <= '0;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_mem_be <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      // starvation only accumulates while the CPU is actually waiting
      r_starve <= (!i_cpu_req || (w_idle_gnt && w_cpu_gnt)) ? '0 :
                  (w_idle_gnt && r_starve != CNT_W'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
      case (r_state)
        IDLE:
          if (w_valid) begin
            r_gnt <= w_grant;
            r_we <= w_we;
            if (w_in_range) begin
              r_mem_addr <= VRAM_BASE + MADDR_W'(w_addr);
              r_mem_dout <= w_cpu_gnt ? i_cpu_wdata : '0;
              r_mem_be <= w_we ? i_cpu_be : 2'b11;
              r_mem_rd <= !w_we;
              r_mem_wr <= w_we;
              r_state <= ACCESS;
            end else begin
              r_state <= DONE;
              r_cpu_ack <= w_cpu_gnt;
              r_vid_ack <= !w_cpu_gnt;
              if (w_cpu_gnt && !w_we) r_cpu_rdata <= '0;
              if (!w_cpu_gnt) r_vid_rdata <= '0;
            end
          end
        ACCESS:
          if (i_mem_ready || w_tmo) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_state <= DONE;
            r_cpu_ack <= r_gnt == GNT_CPU;
            r_vid_ack <= r_gnt == GNT_VID;
            if (r_gnt == GNT_CPU && !r_we) r_cpu_rdata <= w_rdata;
            if (r_gnt == GNT_VID) r_vid_rdata <= w_rdata;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign o_vid_ack = r_vid_ack;
  assign o_cpu_ack = r_cpu_ack;
  assign o_vid_rdata = r_vid_rdata;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_dout = r_mem_dout;
  assign o_mem_be = r_mem_be;
  assign o_mem_rd = r_mem_rd;
  assign o_mem_wr = r_mem_wr;
  assign o_busy = r_state != IDLE;
endmodule
